// File: rtl/barrel_shift_pkg.sv
// Shared types and constants for the two-requester barrel shift arbiter.
package barrel_shift_pkg;

  localparam int BS_N = 3;
  localparam int BS_W = 2 ** BS_N;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  typedef struct packed {
    logic [BS_W-1:0] a;
    logic [BS_N-1:0] amt;
    logic            dir;
  } shift_op_t;

endpackage

// File: rtl/multi_barrel_shifter_mux.sv
// Logarithmic rotator: stage gi rotates by 2**gi when amt[gi] is set.
module multi_barrel_shifter_mux
  import barrel_shift_pkg::*;
#(
  parameter int N     = 3,
  parameter int Width = 2 ** N
) (
  input  logic [Width-1:0] a,
  input  logic [N-1:0]     amt,
  input  logic             select,
  output logic [Width-1:0] y
);

  logic [Width-1:0] stage [0:N];

  assign stage[0] = a;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      localparam int S = 2 ** gi;
      logic [Width-1:0] rot_left;
      logic [Width-1:0] rot_right;

      assign rot_left  = {stage[gi][Width-S-1:0], stage[gi][Width-1:Width-S]};
      assign rot_right = {stage[gi][S-1:0], stage[gi][Width-1:S]};
      assign stage[gi+1] = amt[gi] ? ((select == DIR_LEFT) ? rot_left : rot_right)
                                   : stage[gi];
    end
  endgenerate

  assign y = stage[N];

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin sharing of one rotator between two requesters, with a single
// registered, backpressured response slot and a saturating completion counter.
module barrel_shift_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int N     = BS_N,
  parameter int Width = 2 ** N,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [Width-1:0] req0_a,
  input  logic [N-1:0]     req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [Width-1:0] req1_a,
  input  logic [N-1:0]     req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_y,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rsp_state_t       state_reg;
  rsp_state_t       state_next;
  logic             last_grant_reg;
  logic [Width-1:0] rsp_y_reg;
  logic             rsp_id_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             grant0;
  logic             grant1;
  logic             grant_any;
  shift_op_t        op0;
  shift_op_t        op1;
  shift_op_t        op_sel;
  logic [Width-1:0] shift_y;

  assign accept = (state_reg == EMPTY) | rsp_ready;

  // Each ready looks only at the other port's valid, so a requester never
  // sees its own valid reflected combinationally in its ready.
  assign req0_ready = accept & (last_grant_reg | ~req1_valid);
  assign req1_ready = accept & (~last_grant_reg | ~req0_valid);

  assign grant0    = req0_valid & req0_ready;
  assign grant1    = req1_valid & req1_ready;
  assign grant_any = grant0 | grant1;

  assign op0    = '{a: req0_a, amt: req0_amt, dir: req0_dir};
  assign op1    = '{a: req1_a, amt: req1_amt, dir: req1_dir};
  assign op_sel = grant1 ? op1 : op0;

  multi_barrel_shifter_mux #(
    .N     (N),
    .Width (Width)
  ) u_shifter (
    .a      (op_sel.a),
    .amt    (op_sel.amt),
    .select (op_sel.dir),
    .y      (shift_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (grant_any) state_next = FULL;
      FULL:    if (rsp_ready && !grant_any) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_reg == FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_y_reg      <= '0;
      rsp_id_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (grant_any) begin
      rsp_y_reg      <= shift_y;
      rsp_id_reg     <= grant1;
      last_grant_reg <= grant1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (rsp_valid && rsp_ready && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign rsp_y    = rsp_y_reg;
  assign rsp_id   = rsp_id_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Scoreboard bench: drivers push expected results on each accepted request,
// a monitor pops and compares on each response handshake.
module tb_barrel_shift_arbiter;

  typedef struct {
    logic [7:0] y;
    logic       id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [7:0]  req0_a = '0;
  logic [2:0]  req0_amt = '0;
  logic        req0_dir = 1'b0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [7:0]  req1_a = '0;
  logic [2:0]  req1_amt = '0;
  logic        req1_dir = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_y;
  logic        rsp_id;
  logic [15:0] op_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_count = '0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  exp_t        t4_e;

  barrel_shift_arbiter #(
    .N     (3),
    .Width (8),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_amt   (req0_amt),
    .req0_dir   (req0_dir),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_amt   (req1_amt),
    .req1_dir   (req1_dir),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_id     (rsp_id),
    .op_count   (op_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the request is accepted.
  task automatic send(input bit port, input logic [7:0] a, input logic [2:0] amt,
                      input logic dir, input logic [7:0] exp_y);
    exp_t e;
    bit   done;
    done = 1'b0;
    e.y  = exp_y;
    e.id = port;
    if (port == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_amt = amt; req0_dir = dir;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_amt = amt; req1_dir = dir;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (((port == 1'b0) ? req0_ready : req1_ready) === 1'b1) begin
        sb_q.push_back(e);
        done = 1'b1;
        $display("req%0d a=%h amt=%0d dir=%0d exp_y=%h", port, a, amt, dir, exp_y);
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout port=%0d actual=not_ready required=ready", port);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset_n && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=y%h_id%0d required=none", rsp_y, rsp_id);
        end else begin
          mon_e = sb_q.pop_front();
          $display("rsp y=%h id=%0d count=%h", rsp_y, rsp_id, op_count);
          chk("rsp_y", {24'd0, rsp_y}, {24'd0, mon_e.y});
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
          chk("op_count", {16'd0, op_count}, {16'd0, model_count});
          if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
        end
      end
    end
  end

  initial begin
    #2;
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_y", {24'd0, rsp_y}, 32'd0);
    chk("reset_id", {31'd0, rsp_id}, 32'd0);
    chk("reset_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Single left rotate from requester 0.
    send(1'b0, 8'h96, 3'd3, 1'b0, 8'hB4);
    req0_valid = 1'b0;
    #3;
    chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_y", {24'd0, rsp_y}, 32'h0000_00B4);
    @(negedge clk);

    // Right rotate, then pass-through with amt=0, back to back.
    send(1'b1, 8'h96, 3'd3, 1'b1, 8'hD2);
    send(1'b1, 8'h96, 3'd0, 1'b1, 8'h96);
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Both requesters contend: grants alternate 0,1,0,1 with no bubbles.
    fork
      begin
        send(1'b0, 8'h01, 3'd1, 1'b0, 8'h02);
        send(1'b0, 8'h80, 3'd1, 1'b0, 8'h01);
        req0_valid = 1'b0;
      end
      begin
        send(1'b1, 8'h01, 3'd1, 1'b1, 8'h80);
        send(1'b1, 8'hF0, 3'd4, 1'b1, 8'h0F);
        req1_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #3;
          chk("t3_no_bubble", {31'd0, rsp_valid}, 32'd1);
        end
      end
    join
    @(negedge clk);
    @(negedge clk);

    // Backpressure: result held stable, no request accepted.
    rsp_ready = 1'b0;
    send(1'b0, 8'h0F, 3'd2, 1'b0, 8'h3C);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_amt = 3'd1; req1_dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_hold_y", {24'd0, rsp_y}, 32'h0000_003C);
      chk("t4_hold_id", {31'd0, rsp_id}, 32'd0);
      chk("t4_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("t4_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4_req1_release", {31'd0, req1_ready}, 32'd1);
    t4_e.y = 8'h55;
    t4_e.id = 1'b1;
    sb_q.push_back(t4_e);
    $display("req1 a=aa amt=1 dir=1 exp_y=55");
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset while FULL discards the held result; req0 wins first afterwards.
    rsp_ready = 1'b0;
    send(1'b0, 8'h11, 3'd0, 1'b0, 8'h11);
    req0_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_rst_y", {24'd0, rsp_y}, 32'd0);
    chk("t5_rst_count", {16'd0, op_count}, 32'd0);
    sb_q.delete();
    model_count = '0;
    @(negedge clk);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    fork
      begin
        send(1'b0, 8'h01, 3'd7, 1'b0, 8'h80);
        req0_valid = 1'b0;
      end
      begin
        send(1'b1, 8'h02, 3'd1, 1'b1, 8'h01);
        req1_valid = 1'b0;
      end
    join
    @(negedge clk);
    @(negedge clk);

    // Counter saturation.
    force dut.count_reg = 16'hFFFE;
    model_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.count_reg;
    #3;
    chk("t6_preload", {16'd0, op_count}, 32'h0000_FFFE);
    @(negedge clk);
    send(1'b0, 8'h01, 3'd1, 1'b0, 8'h02);
    send(1'b0, 8'h02, 3'd2, 1'b0, 8'h08);
    send(1'b0, 8'h03, 3'd0, 1'b0, 8'h03);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("t6_saturated", {16'd0, op_count}, 32'h0000_FFFF);
    @(negedge clk);
    @(negedge clk);
    #3;
    chk("t6_hold", {16'd0, op_count}, 32'h0000_FFFF);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
